// File: rtl/count_sequencer_pkg.sv
// Shared encodings for the count sequencer and the 4-bit load/up/down counter it drives.
package count_sequencer_pkg;

    localparam logic [1:0] CTL_CLR = 2'd0;
    localparam logic [1:0] CTL_UP  = 2'd1;
    localparam logic [1:0] CTL_DN  = 2'd2;
    localparam logic [1:0] CTL_LD  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/count_sequencer_if.sv
// Software/config side of the sequencer: run control, configuration and status.
interface count_sequencer_if #(
    parameter int WIDTH  = 4,
    parameter int PASS_W = 8
);
    logic              start_i;
    logic              abort_i;
    logic              pause_i;
    logic [WIDTH-1:0]  cfg_start_i;
    logic [WIDTH-1:0]  cfg_end_i;
    logic              cfg_down_i;
    logic              cfg_reload_i;
    logic              busy_o;
    logic              done_o;
    logic [PASS_W-1:0] pass_cnt_o;

    modport master (
        output start_i, abort_i, pause_i, cfg_start_i, cfg_end_i, cfg_down_i, cfg_reload_i,
        input  busy_o, done_o, pass_cnt_o
    );

    modport slave (
        input  start_i, abort_i, pause_i, cfg_start_i, cfg_end_i, cfg_down_i, cfg_reload_i,
        output busy_o, done_o, pass_cnt_o
    );
endinterface

// File: rtl/counter4bit.sv
// Load/up/down counter datapath (0=clear, 1=up, 2=down, 3=load), async active-high reset.
module counter4bit
    import count_sequencer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic [1:0]       ctl_i,
    input  logic [WIDTH-1:0] load_i,
    output logic [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            case (ctl_i)
                CTL_CLR: count_q <= '0;
                CTL_UP:  count_q <= count_q + WIDTH'(1);
                CTL_DN:  count_q <= count_q - WIDTH'(1);
                default: count_q <= load_i;
            endcase
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/count_sequencer.sv
// Run controller for counter4bit: load start, step toward end, then hold or auto-reload.
module count_sequencer
    import count_sequencer_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int PASS_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    count_sequencer_if.slave bus,
    input  logic [WIDTH-1:0] count_i,
    output logic [1:0]       ctl_o,
    output logic [WIDTH-1:0] load_o
);
    state_e            state_q, state_d;
    logic [WIDTH-1:0]  cfg_start_q, cfg_end_q;
    logic              cfg_down_q, cfg_reload_q;
    logic [PASS_W-1:0] pass_q;
    logic              latch, pass_inc, done;

    // The counter has no hold code, so every non-stepping cycle reloads its own value.
    always_comb begin
        state_d  = state_q;
        ctl_o    = CTL_LD;
        load_o   = count_i;
        done     = 1'b0;
        latch    = 1'b0;
        pass_inc = 1'b0;
        if (reset_n) begin
            if (bus.abort_i) begin
                ctl_o   = CTL_CLR;
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (bus.start_i) begin
                            latch   = 1'b1;
                            state_d = ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        load_o  = cfg_start_q;
                        state_d = ST_RUN;
                    end
                    // PAUSE released evaluates exactly like RUN in the same cycle.
                    ST_RUN, ST_PAUSE: begin
                        if (bus.pause_i) begin
                            state_d = ST_PAUSE;
                        end else if (count_i == cfg_end_q) begin
                            done     = 1'b1;
                            pass_inc = 1'b1;
                            if (cfg_reload_q) begin
                                load_o  = cfg_start_q;
                                state_d = ST_RUN;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            ctl_o   = cfg_down_q ? CTL_DN : CTL_UP;
                            state_d = ST_RUN;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cfg_start_q  <= '0;
            cfg_end_q    <= '0;
            cfg_down_q   <= 1'b0;
            cfg_reload_q <= 1'b0;
            pass_q       <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                cfg_start_q  <= bus.cfg_start_i;
                cfg_end_q    <= bus.cfg_end_i;
                cfg_down_q   <= bus.cfg_down_i;
                cfg_reload_q <= bus.cfg_reload_i;
                pass_q       <= '0;
            end else if (pass_inc) begin
                pass_q <= pass_q + PASS_W'(1);
            end
        end
    end

    assign bus.busy_o     = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign bus.done_o     = done;
    assign bus.pass_cnt_o = pass_q;
endmodule
